// File: rtl/operand_fetch_stage.sv
// ID-stage operand collector and ID/EX pipeline register. It forwards EX/MEM and MEM/WB
// results over bank data, and it inserts load-use bubbles through a RUN/STALL FSM.
module operand_fetch_stage #(
    parameter int NB_DATA          = 32,
    parameter int NB_REGISTER      = 5,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_instr_valid,
    input  logic [NB_REGISTER-1:0] i_rs_sel,
    input  logic [NB_REGISTER-1:0] i_rt_sel,
    input  logic [NB_REGISTER-1:0] i_dest_sel,
    input  logic                   i_reg_write,
    input  logic                   i_mem_read,
    input  logic                   i_flush,
    input  logic [NB_DATA-1:0]     i_data_read_reg_0,
    input  logic [NB_DATA-1:0]     i_data_read_reg_1,
    input  logic [NB_REGISTER-1:0] i_exmem_dest,
    input  logic                   i_exmem_reg_write,
    input  logic [NB_DATA-1:0]     i_exmem_data,
    input  logic [NB_REGISTER-1:0] i_memwb_dest,
    input  logic                   i_memwb_reg_write,
    input  logic [NB_DATA-1:0]     i_memwb_data,
    output logic [NB_REGISTER-1:0] o_read_reg_sel_0,
    output logic [NB_REGISTER-1:0] o_read_reg_sel_1,
    output logic                   o_stall,
    output logic [NB_DATA-1:0]     o_operand_a,
    output logic [NB_DATA-1:0]     o_operand_b,
    output logic [NB_REGISTER-1:0] o_dest_sel,
    output logic                   o_reg_write,
    output logic                   o_mem_read,
    output logic                   o_out_valid
);

    localparam int CNT_W = (LOAD_USE_BUBBLES > 1) ? $clog2(LOAD_USE_BUBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_USE_BUBBLES - 1);

    typedef enum logic {RUN, STALL} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NB_DATA-1:0]     operand_a_q, operand_a_d;
    logic [NB_DATA-1:0]     operand_b_q, operand_b_d;
    logic [NB_REGISTER-1:0] dest_sel_q, dest_sel_d;
    logic                   reg_write_q, reg_write_d;
    logic                   mem_read_q, mem_read_d;
    logic                   out_valid_q, out_valid_d;
    logic                   hazard;

    // Register 0 reads as zero and is never forwarded. EX/MEM is newer than MEM/WB, so it wins.
    function automatic logic [NB_DATA-1:0] fwd_operand(
        input logic [NB_REGISTER-1:0] sel,
        input logic [NB_DATA-1:0]     bank_data,
        input logic                   exmem_we,
        input logic [NB_REGISTER-1:0] exmem_dest,
        input logic [NB_DATA-1:0]     exmem_data,
        input logic                   memwb_we,
        input logic [NB_REGISTER-1:0] memwb_dest,
        input logic [NB_DATA-1:0]     memwb_data
    );
        if (sel == '0)
            return '0;
        else if (exmem_we && exmem_dest == sel && exmem_dest != '0)
            return exmem_data;
        else if (memwb_we && memwb_dest == sel && memwb_dest != '0)
            return memwb_data;
        else
            return bank_data;
    endfunction

    assign o_read_reg_sel_0 = i_rs_sel;
    assign o_read_reg_sel_1 = i_rt_sel;

    assign hazard = (state_q == RUN) && i_instr_valid && out_valid_q && mem_read_q &&
                    (dest_sel_q != '0) &&
                    ((dest_sel_q == i_rs_sel) || (dest_sel_q == i_rt_sel));
    assign o_stall = hazard || (state_q == STALL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        dest_sel_d  = dest_sel_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        out_valid_d = out_valid_q;
        // A bubble clears only the control flags. Operands and dest keep their last values.
        if (i_flush) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            state_d     = RUN;
            cnt_d       = '0;
        end else if (state_q == STALL) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            cnt_d       = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
                state_d = RUN;
        end else if (hazard) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            cnt_d       = CNT_INIT;
            if (CNT_INIT != '0)
                state_d = STALL;
        end else if (i_instr_valid) begin
            operand_a_d = fwd_operand(i_rs_sel, i_data_read_reg_0, i_exmem_reg_write,
                                      i_exmem_dest, i_exmem_data, i_memwb_reg_write,
                                      i_memwb_dest, i_memwb_data);
            operand_b_d = fwd_operand(i_rt_sel, i_data_read_reg_1, i_exmem_reg_write,
                                      i_exmem_dest, i_exmem_data, i_memwb_reg_write,
                                      i_memwb_dest, i_memwb_data);
            dest_sel_d  = i_dest_sel;
            reg_write_d = i_reg_write;
            mem_read_d  = i_mem_read;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            dest_sel_q  <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (i_valid) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            dest_sel_q  <= dest_sel_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_operand_a = operand_a_q;
    assign o_operand_b = operand_b_q;
    assign o_dest_sel  = dest_sel_q;
    assign o_reg_write = reg_write_q;
    assign o_mem_read  = mem_read_q;
    assign o_out_valid = out_valid_q;

endmodule
